// File: rtl/sc_io_pkg.sv
// Shared definitions for the CPU's memory-mapped input peripheral:
// register addresses, EVENT field positions and the address decoder.
package sc_io_pkg;

    localparam logic [31:0] IO_SW_ADDR       = 32'hffff_ff60;
    localparam logic [31:0] IO_SW_ALIAS_ADDR = 32'hffff_ff64;
    localparam logic [31:0] IO_KEY_ADDR      = 32'hffff_ff68;
    localparam logic [31:0] IO_EVENT_ADDR    = 32'hffff_ff6c;
    localparam logic [31:0] IO_IRQEN_ADDR    = 32'hffff_ff70;

    localparam int unsigned EV_SW_LSB  = 0;
    localparam int unsigned EV_KEY_LSB = 8;
    localparam int unsigned N_SW       = 8;
    localparam int unsigned N_KEY      = 4;
    localparam int unsigned N_IN       = N_SW + N_KEY;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_SW,
        REG_KEY,
        REG_EVENT,
        REG_IRQEN
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        reg_sel_e sel;
        case (addr)
            IO_SW_ADDR,
            IO_SW_ALIAS_ADDR: sel = REG_SW;
            IO_KEY_ADDR:      sel = REG_KEY;
            IO_EVENT_ADDR:    sel = REG_EVENT;
            IO_IRQEN_ADDR:    sel = REG_IRQEN;
            default:          sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sc_debounce.sv
// One input bit: two-flop synchronizer, debounce counter and stable flop.
// rise/fall pulse in the cycle whose clock edge updates stable.
module sc_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] count;
    logic             differ;
    logic             update;

    assign differ = (sync[1] != stable);
    assign update = differ && (count == CNT_LAST);

    // Pulses are combinational so that events land on the same edge as stable.
    assign rise = update && sync[1];
    assign fall = update && !sync[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            sync   <= '0;
            stable <= 1'b0;
            count  <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (!differ) begin
                count <= '0;
            end else if (update) begin
                stable <= sync[1];
                count  <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sc_io_input.sv
// Memory-mapped switch/push-button input peripheral with sticky change/press
// events, per-event interrupt enables and a registered read port.
module sc_io_input
    import sc_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        we,
    input  logic [31:0] datain,
    input  logic [7:0]  switch_input,
    input  logic [3:0]  key_input,
    output logic [31:0] dataout,
    output logic        irq
);

    logic [N_IN-1:0] raw;
    logic [N_IN-1:0] stable;
    logic [N_IN-1:0] rise;
    logic [N_IN-1:0] fall;
    logic [N_IN-1:0] ev_set;
    logic [N_IN-1:0] ev_clr;
    logic [N_IN-1:0] ev_q;
    logic [N_IN-1:0] en_q;
    logic [31:0]     read_mux;
    reg_sel_e        sel;
    logic            unused_bits;

    // Keys are active-low on the board; internally 1 means pressed.
    assign raw = {~key_input, switch_input};

    for (genvar i = 0; i < N_IN; i++) begin : g_bit
        sc_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clock (clock),
            .reset (reset),
            .raw   (raw[i]),
            .stable(stable[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    assign ev_set[EV_SW_LSB +: N_SW]   = rise[EV_SW_LSB +: N_SW] | fall[EV_SW_LSB +: N_SW];
    assign ev_set[EV_KEY_LSB +: N_KEY] = rise[EV_KEY_LSB +: N_KEY];
    assign unused_bits = ^{datain[31:N_IN], fall[EV_KEY_LSB +: N_KEY]};

    assign sel    = decode_addr(addr);
    assign ev_clr = (we && sel == REG_EVENT) ? datain[N_IN-1:0] : '0;
    assign irq    = |(ev_q & en_q);

    always_comb begin
        read_mux = '0;
        case (sel)
            REG_SW:    read_mux = {24'b0, stable[EV_SW_LSB +: N_SW]};
            REG_KEY:   read_mux = {28'b0, stable[EV_KEY_LSB +: N_KEY]};
            REG_EVENT: read_mux = {20'b0, ev_q};
            REG_IRQEN: read_mux = {20'b0, en_q};
            default:   read_mux = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dataout <= '0;
            ev_q    <= '0;
            en_q    <= '0;
        end else begin
            if (rd) begin
                dataout <= read_mux;
            end
            if (we && sel == REG_IRQEN) begin
                en_q <= datain[N_IN-1:0];
            end
            // A new event on the same edge as a W1C keeps the bit set.
            ev_q <= (ev_q & ~ev_clr) | ev_set;
        end
    end

endmodule

// File: doc/sc_io_input.md
# sc_io_input

Memory-mapped input peripheral for the single-cycle CPU's IO space (addr[31] = 1). Samples the board's 8 slide switches and 4 push-buttons, synchronizes and debounces them, records change/press events in sticky status bits and raises an interrupt request. It answers CPU reads and writes at 0xffffff60–0xffffff70. It is the input counterpart of the display-write path in the data-memory block, and its dataout feeds the IO leg of the memory/IO read mux.

## Interface
- DEBOUNCE_CYCLES, default 50000: number of consecutive cycles a synchronized input must differ from its debounced value before the debounced value updates; legal range 2 .. 2^CNT_W−1.
- CNT_W, default 16: width of each per-bit debounce counter.
- clock  in  1: sole clock; all state updates on posedge.
- reset  in  1: synchronous, active-high.
- addr  in  32: CPU byte address.
- rd  in  1: read strobe.
- we  in  1: write strobe.
- datain  in  32: CPU write data.
- switch_input  in  8: raw slide switches, asynchronous, 1 = on.
- key_input  in  4: raw push-buttons, asynchronous, active-low (0 = pressed).
- dataout  out  32: registered read data.
- irq  out  1: level interrupt request.

## Operation
- Input path, per bit (12 bits: sw[7:0], key[3:0] inverted to 1 = pressed): two-flop synchronizer, then debounce counter.
- Debounce: if sync == stable, counter ← 0. Otherwise, if counter == DEBOUNCE_CYCLES−1, then stable ← sync and counter ← 0; else counter ← counter+1.
- Events: sw_chg[i] sets whenever stable sw[i] changes in either direction. key_prs[j] sets only when stable key[j] goes 0→1 (press). Both are sticky.
- Register map (full 32-bit address decode):
  - 0xffffff60 SW (RO): {24'b0, sw_stable}.
  - 0xffffff64 SW alias (RO): same value.
  - 0xffffff68 KEY (RO): {28'b0, key_stable}.
  - 0xffffff6c EVENT (RW1C): {20'b0, key_prs[3:0], sw_chg[7:0]}. Writing 1 clears the bit; writing 0 leaves it unchanged.
  - 0xffffff70 IRQ_EN (RW): {20'b0, en[11:0]}. datain[31:12] is ignored.
- irq = |(EVENT[11:0] & IRQ_EN[11:0]). It is combinational from registers and is not registered again.
- Reads: when rd is asserted, dataout ← the mapped value, or 0 for any unmapped address. When rd is low, dataout holds its value.
- Writes to RO or unmapped addresses have no effect.

## Timing
- Reset value of every output is 0: dataout = 0, irq = 0. All internal state resets to 0: sync flops, stable values, counters, EVENT, IRQ_EN. Reset never creates events.
- Reset asserted mid-debounce clears the counter. Debouncing restarts from stable = 0 after reset.
- Input-to-stable latency: a raw change held steady before edge k is visible in stable (and in the EVENT bit) after edge k+1+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no change and no event.
- Read latency is 1 cycle: rd/addr sampled at edge k gives dataout valid after edge k.
- A read returns pre-edge register state. An event set on the same edge is seen by the next read.
- A W1C write and an event set on the same bit in the same cycle: the set wins and the bit stays 1.
- rd and we asserted together on EVENT: dataout returns the pre-clear value, and the clear takes effect on that same edge.
- Counters never exceed DEBOUNCE_CYCLES−1, so there is no wrap-around.

## Structure
- Shared package sc_io_pkg holds the address constants:
  - IO_SW_ADDR = 0xffffff60
  - IO_SW_ALIAS_ADDR = 0xffffff64
  - IO_KEY_ADDR = 0xffffff68
  - IO_EVENT_ADDR = 0xffffff6c
  - IO_IRQEN_ADDR = 0xffffff70
  - Bit-field positions: EV_SW_LSB = 0, EV_KEY_LSB = 8.
- One sub-module, sc_debounce. It covers one bit: synchronizer, counter, stable flop and a one-cycle rise/fall pulse. Parameterized by DEBOUNCE_CYCLES and CNT_W, and instantiated 12 times.

## Test plan
Simulate with DEBOUNCE_CYCLES = 4.
1. Reset, then switch_input = 8'hA5 held. Read 0xffffff60 after 7 edges → dataout = 0x000000A5, EVENT = 0x0A5, irq = 0 (en = 0).
2. key_input[2] pulled low for 3 cycles, then back high → KEY = 0 and EVENT = 0 throughout (glitch rejected).
3. IRQ_EN ← 0x100, key_input[0] held low → irq rises after 6 edges and EVENT reads 0x100. Write 0x100 to EVENT → irq drops after the write edge.
4. Key release (key_input[0] back high) → KEY[0] returns to 0 after 6 edges, EVENT[8] stays 0 and irq stays 0.
5. W1C of sw_chg[3] on the same edge that sw[3] debounce completes → EVENT[3] remains 1.
6. rd to 0xffffff74 → dataout = 0. Assert reset while a counter is at 2 → all registers read 0 afterwards, and irq = 0.
